// File: rtl/sp_ram_ctrl.sv
// Request-side controller for a single-port synchronous RAM: sequences cs/we/oe/address,
// owns the controller side of the shared data bus and returns read data on a valid/ready channel.
module sp_ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ADDR,
    S_RD_DATA,
    S_RSP
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    accept;
  logic                    drive_bus;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // All RAM controls decode from the state register alone so they never glitch on inputs.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_oe    = 1'b0;
    drive_bus = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_we ? S_WR : S_RD_ADDR;
      end
      S_WR: begin
        ram_cs    = 1'b1;
        ram_we    = 1'b1;
        drive_bus = 1'b1;
        state_nxt = S_IDLE;
      end
      S_RD_ADDR: begin
        ram_cs    = 1'b1;
        ram_oe    = 1'b1;
        state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        ram_cs    = 1'b1;
        ram_oe    = 1'b1;
        state_nxt = S_RSP;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request fields are captured only on accept; anything presented while busy is ignored.
  always_ff @(posedge clk) begin
    if (rst)         addr_q <= '0;
    else if (accept) addr_q <= req_addr;
  end

  always_ff @(posedge clk) begin
    if (accept) wdata_q <= req_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)                     rsp_rdata <= '0;
    else if (state == S_RD_DATA) rsp_rdata <= ram_data;
  end

  assign ram_addr = addr_q;
  assign ram_data = drive_bus ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Directed bench for sp_ram_ctrl with a behavioural single-port RAM on the shared bus.
// A pull-up on the bus makes a released bus read back as all ones.
module tb_sp_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       ram_cs;
  logic       ram_we;
  logic       ram_oe;
  logic [7:0] ram_addr;
  wire  [7:0] ram_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [7:0] exp_wdata = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sp_ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data)
  );

  // Behavioural RAM: latches mem[addr] on a read-cycle edge, drives it in the following read cycle.
  logic [7:0] mem [256];
  logic [7:0] ram_dout = 8'h00;
  logic       ram_rd_v = 1'b0;
  logic       ram_drive;

  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
    if (ram_cs && ram_oe && !ram_we) begin
      ram_dout <= mem[ram_addr];
      ram_rd_v <= 1'b1;
    end else begin
      ram_rd_v <= 1'b0;
    end
  end

  assign ram_drive = ram_cs && ram_oe && !ram_we && ram_rd_v;
  assign ram_data  = ram_drive ? ram_dout : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (ram_data[g]);
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Bus ownership monitor.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ram_cs && ram_we)  chk_val("bus_wr", ram_data, exp_wdata);
      else if (ram_drive)    chk_val("bus_rd", ram_data, ram_dout);
      else                   chk_val("bus_rel", ram_data, 8'hFF);
      chk_val("oe_we_excl", ram_oe & ram_we, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output int acc);
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        return;
      end
      @(negedge clk);
    end
    chk_val("accept_timeout", 0, 1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input bit keep, output int acc);
    req_we = 1'b1; req_addr = a; req_wdata = d; req_valid = 1'b1;
    exp_wdata = d;
    wait_accept(acc);
    if (keep) begin
      req_we = 1'b0; req_addr = ~a; req_wdata = 8'hEE;
    end else begin
      req_valid = 1'b0;
    end
    @(negedge clk);
    chk_val("wr_ctl", {ram_cs, ram_we, ram_oe}, 3'b110);
    chk_val("wr_addr", ram_addr, a);
    chk_val("wr_busy", req_ready, 0);
    tick();
    chk_val("wr_mem", mem[a], d);
    @(negedge clk);
    chk_val("wr_ready_back", req_ready, 1);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input int hold,
                         input bit keep, output int acc);
    req_we = 1'b0; req_addr = a; req_valid = 1'b1; rsp_ready = 1'b0;
    wait_accept(acc);
    if (keep) begin
      req_we = 1'b1; req_addr = ~a; req_wdata = 8'hEE;
    end else begin
      req_valid = 1'b0;
    end
    @(negedge clk);
    chk_val("rd_addr_ctl", {ram_cs, ram_we, ram_oe}, 3'b101);
    chk_val("rd_addr", ram_addr, a);
    chk_val("rd_addr_vld", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk_val("rd_data_ctl", {ram_cs, ram_we, ram_oe}, 3'b101);
    chk_val("rd_data_vld", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk_val("rsp_vld", rsp_valid, 1);
    chk_val("rsp_data", rsp_rdata, exp);
    chk_val("rsp_ctl", {ram_cs, ram_we, ram_oe}, 3'b000);
    chk_val("rsp_busy", req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      @(negedge clk);
      chk_val("bp_vld", rsp_valid, 1);
      chk_val("bp_data", rsp_rdata, exp);
      chk_val("bp_busy", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk_val("hs_vld_low", rsp_valid, 0);
    chk_val("hs_ready", req_ready, 1);
  endtask

  initial begin
    int cw, cr;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00;
    req_wdata = 8'h00; rsp_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk_val("rst_ready", req_ready, 1);
    chk_val("rst_vld", rsp_valid, 0);
    chk_val("rst_rdata", rsp_rdata, 0);
    chk_val("rst_addr", ram_addr, 0);
    chk_val("rst_ctl", {ram_cs, ram_we, ram_oe}, 3'b000);
    chk_val("rst_bus", ram_data, 8'hFF);
    rst = 1'b0;
    mon_en = 1'b1;

    // Basic write then read back.
    do_write(8'h10, 8'hA5, 1'b0, cw);
    do_read(8'h10, 8'hA5, 0, 1'b0, cr);

    // Address extremes.
    do_write(8'h00, 8'h3C, 1'b0, cw);
    do_write(8'hFF, 8'hC3, 1'b0, cw);
    do_read(8'h00, 8'h3C, 0, 1'b0, cr);
    do_read(8'hFF, 8'hC3, 0, 1'b0, cr);

    // Response backpressure for 5 cycles.
    do_read(8'h10, 8'hA5, 5, 1'b0, cr);

    // Back-to-back stream with req_valid held and junk fields while busy.
    for (int k = 0; k < 16; k++) begin
      do_write(8'h80 + 8'(k), 8'(k), 1'b1, cw);
      do_read(8'h80 + 8'(k), 8'(k), 0, 1'b1, cr);
      chk_val("wr_spacing", cr - cw, 2);
    end
    req_valid = 1'b0;
    chk_val("junk_not_written", mem[8'h7F], 8'h00);

    // Reset during RD_DATA discards the read.
    req_we = 1'b0; req_addr = 8'h10; req_valid = 1'b1; rsp_ready = 1'b1;
    wait_accept(cr);
    req_valid = 1'b0;
    tick();
    @(negedge clk);
    chk_val("pre_rst_rd_data", {ram_cs, ram_we, ram_oe}, 3'b101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_val("rrst_vld", rsp_valid, 0);
    chk_val("rrst_ctl", {ram_cs, ram_we, ram_oe}, 3'b000);
    chk_val("rrst_bus", ram_data, 8'hFF);
    chk_val("rrst_ready", req_ready, 1);
    chk_val("rrst_addr", ram_addr, 0);
    chk_val("rrst_rdata", rsp_rdata, 0);
    tick();
    @(negedge clk);
    chk_val("rrst_vld2", rsp_valid, 0);

    // Reset coinciding with the WR cycle: the write still lands.
    req_we = 1'b1; req_addr = 8'h30; req_wdata = 8'h77; req_valid = 1'b1;
    exp_wdata = 8'h77;
    wait_accept(cw);
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_val("wrst_mem", mem[8'h30], 8'h77);
    chk_val("wrst_ctl", {ram_cs, ram_we, ram_oe}, 3'b000);
    chk_val("wrst_ready", req_ready, 1);
    do_read(8'h30, 8'h77, 0, 1'b0, cr);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
